lookup_match_stage: RTL and testbench

Per-stage exact/ternary match engine that sits directly downstream of the key extractor in each RMT stage. It consumes the extracted key and PHV, compares the key against a small register-based table of masked entries, and emits the lowest-index hit address plus a hit flag, with the PHV delayed to stay aligned. The downstream action engine uses the address to fetch its action.

---
 rtl/lookup_match_stage.sv | 168 ++++++++++++++++
 tb/tb_lookup_match_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup_match_stage.sv
// Masked exact/ternary match stage: compares the extracted key against a flop-based
// entry table, reports the lowest-index hit, and keeps the PHV aligned (2-cycle latency).
// Build macro LOOKUP_MATCH_CNT_EN enables the saturating hit/miss counters.
module lookup_match_stage #(
    parameter int STAGE      = 0,
    parameter int PHV_LEN    = 1124,
    parameter int KEY_LEN    = 197,
    parameter int ENTRIES    = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AXIL_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PHV_LEN-1:0]    phv_in,
    input  logic                  phv_valid_in,
    input  logic [KEY_LEN-1:0]    key_in,
    input  logic                  key_valid_in,
    input  logic [AXIL_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    input  logic [ADDR_WIDTH-1:0] cfg_addr,
    input  logic [3:0]            cfg_word,
    input  logic                  cnt_clr,
    output logic [PHV_LEN-1:0]    phv_out,
    output logic                  phv_valid_out,
    output logic [ADDR_WIDTH-1:0] match_addr,
    output logic                  match_hit,
    output logic                  match_valid,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int         MASK_BASE   = 7;
    localparam logic [3:0] WORD_COMMIT = 4'd14;

    // STAGE only picks a status tap that is not exported from this block.
    if (STAGE > 4) begin : g_stage_out_of_range
    end

    logic [KEY_LEN-1:0]    shadow_key_reg;
    logic [KEY_LEN-1:0]    shadow_mask_reg;
    logic [KEY_LEN-1:0]    entry_key_reg  [ENTRIES];
    logic [KEY_LEN-1:0]    entry_mask_reg [ENTRIES];
    logic [ENTRIES-1:0]    entry_valid_reg;
    logic [ENTRIES-1:0]    match_vec;
    logic [ENTRIES-1:0]    match_vec_reg;
    logic [PHV_LEN-1:0]    phv_s1_reg;
    logic                  phv_valid_s1_reg;
    logic                  key_valid_s1_reg;
    logic                  enc_hit;
    logic [ADDR_WIDTH-1:0] enc_addr;
    logic                  commit;

    assign commit = cfg_valid && (cfg_word == WORD_COMMIT);

    // Shadow bits beyond KEY_LEN are never stored, so their config bits simply drop.
    for (genvar gi = 0; gi < KEY_LEN; gi++) begin : g_shadow
        localparam int WORD = gi / AXIL_WIDTH;
        localparam int BIT  = gi % AXIL_WIDTH;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                shadow_key_reg[gi]  <= 1'b0;
                shadow_mask_reg[gi] <= 1'b0;
            end else if (cfg_valid) begin
                if (cfg_word == 4'(WORD))
                    shadow_key_reg[gi] <= cfg_data[BIT];
                if (cfg_word == 4'(MASK_BASE + WORD))
                    shadow_mask_reg[gi] <= cfg_data[BIT];
            end
        end
    end

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic sel;
        assign sel = commit && (cfg_addr == ADDR_WIDTH'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                entry_valid_reg[gi] <= 1'b0;
            else if (sel)
                entry_valid_reg[gi] <= cfg_data[0];
        end

        // Key/mask contents are qualified by the valid bit, so they need no reset.
        always_ff @(posedge clk) begin
            if (sel) begin
                entry_key_reg[gi]  <= shadow_key_reg;
                entry_mask_reg[gi] <= shadow_mask_reg;
            end
        end

        assign match_vec[gi] = entry_valid_reg[gi] &&
                               (((key_in ^ entry_key_reg[gi]) & entry_mask_reg[gi]) == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_s1_reg       <= '0;
            phv_valid_s1_reg <= 1'b0;
            key_valid_s1_reg <= 1'b0;
            match_vec_reg    <= '0;
        end else begin
            phv_s1_reg       <= phv_in;
            phv_valid_s1_reg <= phv_valid_in;
            key_valid_s1_reg <= key_valid_in;
            match_vec_reg    <= key_valid_in ? match_vec : '0;
        end
    end

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        enc_hit  = 1'b0;
        enc_addr = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (match_vec_reg[i]) begin
                enc_hit  = 1'b1;
                enc_addr = ADDR_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_out       <= '0;
            phv_valid_out <= 1'b0;
            match_addr    <= '0;
            match_hit     <= 1'b0;
            match_valid   <= 1'b0;
        end else begin
            phv_out       <= phv_s1_reg;
            phv_valid_out <= phv_valid_s1_reg;
            match_addr    <= enc_addr;
            match_hit     <= enc_hit;
            match_valid   <= key_valid_s1_reg;
        end
    end

`ifdef LOOKUP_MATCH_CNT_EN
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (cnt_clr) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (match_valid) begin
            if (match_hit) begin
                if (hit_cnt_reg != 32'hFFFF_FFFF)
                    hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end else begin
                if (miss_cnt_reg != 32'hFFFF_FFFF)
                    miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign hit_cnt        = '0;
    assign miss_cnt       = '0;
`endif

endmodule

// File: tb/tb_lookup_match_stage.sv
// Self-checking bench for lookup_match_stage: directed table, hand sequences for
// pipeline/commit corners, and randomized traffic against a behavioural table model.
module tb_lookup_match_stage;
    localparam int PHV_LEN    = 1124;
    localparam int KEY_LEN    = 197;
    localparam int ENTRIES    = 16;
    localparam int ADDR_WIDTH = 4;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [PHV_LEN-1:0]    phv_in = '0;
    logic                  phv_valid_in = 1'b0;
    logic [KEY_LEN-1:0]    key_in = '0;
    logic                  key_valid_in = 1'b0;
    logic [31:0]           cfg_data = '0;
    logic                  cfg_valid = 1'b0;
    logic [ADDR_WIDTH-1:0] cfg_addr = '0;
    logic [3:0]            cfg_word = '0;
    logic                  cnt_clr = 1'b0;
    logic [PHV_LEN-1:0]    phv_out;
    logic                  phv_valid_out;
    logic [ADDR_WIDTH-1:0] match_addr;
    logic                  match_hit;
    logic                  match_valid;
    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    lookup_match_stage dut (
        .clk(clk), .rst_n(rst_n),
        .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .key_in(key_in), .key_valid_in(key_valid_in),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_word(cfg_word),
        .cnt_clr(cnt_clr),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out),
        .match_addr(match_addr), .match_hit(match_hit), .match_valid(match_valid),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic                  valid;
        logic                  hit;
        logic [ADDR_WIDTH-1:0] addr;
        logic [PHV_LEN-1:0]    phv;
        logic                  phv_valid;
    } exp_t;

    typedef struct {
        logic [KEY_LEN-1:0]    key;
        logic                  kv;
        logic                  exp_valid;
        logic                  exp_hit;
        logic [ADDR_WIDTH-1:0] exp_addr;
    } vec_t;

    // Reference model: the table as plain arrays plus the config shadow.
    logic [KEY_LEN-1:0] m_key  [ENTRIES];
    logic [KEY_LEN-1:0] m_mask [ENTRIES];
    logic               m_valid[ENTRIES];
    logic [223:0]       s_key, s_mask;
    logic [31:0]        m_hit, m_miss;
    exp_t               exp_stage, exp_vis;

    task automatic check(input string name, input logic [PHV_LEN-1:0] act, input logic [PHV_LEN-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [KEY_LEN-1:0] rand_key();
        logic [223:0] t;
        for (int w = 0; w < 7; w++) t[32*w +: 32] = $urandom;
        return t[KEY_LEN-1:0];
    endfunction

    function automatic logic [PHV_LEN-1:0] rand_phv();
        logic [1151:0] t;
        for (int w = 0; w < 36; w++) t[32*w +: 32] = $urandom;
        return t[PHV_LEN-1:0];
    endfunction

    function automatic logic [KEY_LEN-1:0] mk_key(input logic [31:0] w1, input logic [31:0] w0);
        return KEY_LEN'({w1, w0});
    endfunction

    function automatic void model_match(input logic [KEY_LEN-1:0] k, output logic hit,
                                        output logic [ADDR_WIDTH-1:0] addr);
        hit  = 1'b0;
        addr = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!hit && m_valid[i] && (((k ^ m_key[i]) & m_mask[i]) == '0)) begin
                hit  = 1'b1;
                addr = ADDR_WIDTH'(i);
            end
        end
    endfunction

    task automatic reset_model();
        for (int i = 0; i < ENTRIES; i++) begin
            m_key[i] = '0; m_mask[i] = '0; m_valid[i] = 1'b0;
        end
        s_key = '0; s_mask = '0; m_hit = '0; m_miss = '0;
        exp_stage = '{valid: 1'b0, hit: 1'b0, addr: '0, phv: '0, phv_valid: 1'b0};
        exp_vis   = exp_stage;
    endtask

    // One clock: predict, advance the model at the edge, compare every output.
    task automatic step();
        exp_t n;
        logic h;
        logic [ADDR_WIDTH-1:0] a;
        int cw;
        model_match(key_in, h, a);
        n.valid     = key_valid_in;
        n.hit       = key_valid_in && h;
        n.addr      = key_valid_in ? a : '0;
        n.phv       = phv_in;
        n.phv_valid = phv_valid_in;
`ifdef LOOKUP_MATCH_CNT_EN
        if (cnt_clr) begin
            m_hit = '0; m_miss = '0;
        end else if (exp_vis.valid) begin
            if (exp_vis.hit) m_hit  = (m_hit  == 32'hFFFF_FFFF) ? m_hit  : m_hit  + 1;
            else             m_miss = (m_miss == 32'hFFFF_FFFF) ? m_miss : m_miss + 1;
        end
`endif
        if (cfg_valid) begin
            cw = int'(cfg_word);
            if (cw < 7)       s_key[32*cw +: 32] = cfg_data;
            else if (cw < 14) s_mask[32*(cw-7) +: 32] = cfg_data;
            else if (cw == 14 && int'(cfg_addr) < ENTRIES) begin
                m_key[cfg_addr]   = s_key[KEY_LEN-1:0];
                m_mask[cfg_addr]  = s_mask[KEY_LEN-1:0];
                m_valid[cfg_addr] = cfg_data[0];
            end
        end
        @(posedge clk);
        #1;
        exp_vis   = exp_stage;
        exp_stage = n;
        check("match_valid", match_valid, exp_vis.valid);
        check("match_hit", match_hit, exp_vis.hit);
        check("match_addr", match_addr, exp_vis.addr);
        check("phv_valid_out", phv_valid_out, exp_vis.phv_valid);
        check("phv_out", phv_out, exp_vis.phv);
        check("hit_cnt", hit_cnt, m_hit);
        check("miss_cnt", miss_cnt, m_miss);
        if (match_valid)
            $display("txn: hit=%0d addr=%0d hit_cnt=%0d miss_cnt=%0d", match_hit, match_addr, hit_cnt, miss_cnt);
    endtask

    task automatic set_idle();
        key_valid_in = 1'b0;
        phv_valid_in = 1'b0;
        cfg_valid    = 1'b0;
        cnt_clr      = 1'b0;
        key_in       = rand_key();
        phv_in       = rand_phv();
    endtask

    task automatic set_key(input logic [KEY_LEN-1:0] k, input logic kv);
        set_idle();
        key_in       = k;
        key_valid_in = kv;
        phv_valid_in = kv;
    endtask

    task automatic cfg_write(input int addr, input int word, input logic [31:0] data);
        set_idle();
        cfg_valid = 1'b1;
        cfg_addr  = ADDR_WIDTH'(addr);
        cfg_word  = 4'(word);
        cfg_data  = data;
        step();
        cfg_valid = 1'b0;
    endtask

    vec_t tbl[6];
    logic [KEY_LEN-1:0] k_two, k_one;
    logic [PHV_LEN-1:0] p1, p2, p3;

    initial begin
        reset_model();
        k_two = mk_key(32'hCAFE_1234, 32'h1234_5678);
        k_one = mk_key(32'h0, 32'h55);
        tbl[0] = '{key: mk_key(0, 32'hAB), kv: 1, exp_valid: 1, exp_hit: 1, exp_addr: 3};
        tbl[1] = '{key: mk_key(0, 32'hAC), kv: 1, exp_valid: 1, exp_hit: 0, exp_addr: 0};
        tbl[2] = '{key: k_two, kv: 1, exp_valid: 1, exp_hit: 1, exp_addr: 2};
        tbl[3] = '{key: {{(KEY_LEN-8){1'b1}}, 8'hAB}, kv: 1, exp_valid: 1, exp_hit: 1, exp_addr: 3};
        tbl[4] = '{key: k_two, kv: 0, exp_valid: 0, exp_hit: 0, exp_addr: 0};
        tbl[5] = '{key: mk_key(32'hCAFF_1234, 32'h1234_5678), kv: 1, exp_valid: 1, exp_hit: 0, exp_addr: 0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_match_valid", match_valid, 1'b0);
        check("rst_match_hit", match_hit, 1'b0);
        check("rst_match_addr", match_addr, 0);
        check("rst_phv_valid", phv_valid_out, 1'b0);
        check("rst_phv_out", phv_out, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;

        // Empty table -> miss two cycles later
        set_key('0, 1'b1); step();
        set_idle(); step();
        check("empty_valid", match_valid, 1'b1);
        check("empty_hit", match_hit, 1'b0);
        check("empty_addr", match_addr, 0);
        set_idle(); step();
`ifdef LOOKUP_MATCH_CNT_EN
        check("empty_miss_cnt", miss_cnt, 32'd1);
`else
        check("empty_miss_cnt", miss_cnt, 32'd0);
`endif

        // Entry 3: low byte 0xAB; entries 5 and 2: K
        cfg_write(0, 0, 32'h0000_00AB);
        cfg_write(0, 7, 32'h0000_00FF);
        cfg_write(3, 14, 32'h1);
        cfg_write(0, 0, 32'h1234_5678);
        cfg_write(0, 7, 32'hFFFF_FFFF);
        cfg_write(0, 1, 32'hCAFE_F00D);
        cfg_write(0, 8, 32'hFFFF_0000);
        cfg_write(5, 14, 32'h1);
        cfg_write(2, 14, 32'h1);

        for (int i = 0; i < 6; i++) begin
            set_key(tbl[i].key, tbl[i].kv); step();
            set_idle(); step();
            check("tbl_valid", match_valid, tbl[i].exp_valid);
            check("tbl_hit", match_hit, tbl[i].exp_hit);
            check("tbl_addr", match_addr, tbl[i].exp_addr);
        end

        // Invalidate entry 2 -> K falls through to entry 5
        cfg_write(2, 14, 32'h0);
        set_key(k_two, 1'b1); step();
        set_idle(); step();
        check("inval_hit", match_hit, 1'b1);
        check("inval_addr", match_addr, 5);

        // Entry 1: low byte 0x55; back-to-back hit/miss/hit
        cfg_write(0, 0, 32'h55);
        cfg_write(0, 7, 32'hFF);
        cfg_write(0, 8, 32'h0);
        cfg_write(1, 14, 32'h1);
        set_key(k_one, 1'b1); p1 = phv_in; step();
        set_key(mk_key(0, 32'h56), 1'b1); p2 = phv_in; step();
        check("b2b_k1_hit", match_hit, 1'b1);
        check("b2b_k1_addr", match_addr, 1);
        check("b2b_k1_phv", phv_out, p1);
        set_key({rand_key() >> 8, 8'h55}, 1'b1); p3 = phv_in; step();
        check("b2b_k2_hit", match_hit, 1'b0);
        check("b2b_k2_phv", phv_out, p2);
        set_idle(); step();
        check("b2b_k3_hit", match_hit, 1'b1);
        check("b2b_k3_addr", match_addr, 1);
        check("b2b_k3_phv", phv_out, p3);

        // Commit to entry 0 in the same cycle as the compare
        cfg_write(0, 0, 32'h77);
        set_key(mk_key(0, 32'h77), 1'b1);
        cfg_valid = 1'b1; cfg_addr = 0; cfg_word = 4'd14; cfg_data = 32'h1;
        step();
        set_key(mk_key(0, 32'h77), 1'b1); step();
        check("race_old_hit", match_hit, 1'b0);
        set_idle(); step();
        check("race_new_hit", match_hit, 1'b1);
        check("race_new_addr", match_addr, 0);

`ifdef LOOKUP_MATCH_CNT_EN
        set_idle(); step();
        force dut.hit_cnt_reg = 32'hFFFF_FFFE;
        #1;
        release dut.hit_cnt_reg;
        m_hit = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            set_key(k_one, 1'b1); step();
        end
        repeat (3) begin set_idle(); step(); end
        check("sat_hit_cnt", hit_cnt, 32'hFFFF_FFFF);
        set_key(k_one, 1'b1); step();
        set_idle(); step();
        set_idle(); cnt_clr = 1'b1; step();
        cnt_clr = 1'b0;
        check("clr_hit_cnt", hit_cnt, 32'd0);
        check("clr_miss_cnt", miss_cnt, 32'd0);
`endif

        // Randomized traffic, commits and compares freely overlapping
        for (int it = 0; it < 400; it++) begin
            int r;
            int e;
            set_idle();
            r = $urandom_range(0, 9);
            if (r < 4) begin
                cfg_valid = 1'b1;
                cfg_addr  = ADDR_WIDTH'($urandom_range(0, ENTRIES - 1));
                cfg_word  = (r == 0) ? 4'd14 : 4'($urandom_range(0, 15));
                cfg_data  = (cfg_word >= 4'd7 && cfg_word <= 4'd13) ? ($urandom & $urandom & $urandom) : $urandom;
                if (cfg_word == 4'd14 && $urandom_range(0, 3) != 0) cfg_data[0] = 1'b1;
            end
            key_valid_in = ($urandom_range(0, 4) != 0);
            phv_valid_in = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 1) == 1) begin
                e = $urandom_range(0, ENTRIES - 1);
                key_in = m_key[e] ^ (rand_key() & ~m_mask[e]);
            end
            cnt_clr = ($urandom_range(0, 30) == 0);
            step();
        end

        // Async reset mid-flight drops the pipeline and the table
        set_key(k_one, 1'b1); step();
        set_idle();
        rst_n = 1'b0;
        #2;
        check("arst_match_valid", match_valid, 1'b0);
        check("arst_phv_valid", phv_valid_out, 1'b0);
        check("arst_phv_out", phv_out, 0);
        check("arst_hit_cnt", hit_cnt, 0);
        reset_model();
        #1;
        rst_n = 1'b1;
        set_idle(); step();
        set_key(k_one, 1'b1); step();
        set_idle(); step();
        check("arst_tbl_valid", match_valid, 1'b1);
        check("arst_tbl_hit", match_hit, 1'b0);
        set_idle(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
